// File: rtl/breath_led_multi.sv
// Multi-channel breathing LED driver: a shared PWM frame and triangle brightness sweep, phase-shifted per channel.
// Optional macro LED_ACTIVE_LOW_EN inverts every led_out bit ("on" drives 0, idle/reset level is 1).
module breath_led_multi #(
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned CNT_1US_MAX = 49,
  parameter int unsigned CNT_1MS_MAX = 999,
  parameter int unsigned CNT_1S_MAX  = 999,
  parameter int unsigned PHASE_STEP  = 250
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [1:0]        mode,
  input  logic [CH_NUM-1:0] en,
  output logic [CH_NUM-1:0] led_out,
  output logic              cycle_done
);

  localparam int unsigned N       = CNT_1S_MAX + 1;
  localparam int unsigned POS_MAX = 2 * N - 1;
  localparam int unsigned US_W    = (CNT_1US_MAX > 0) ? $clog2(CNT_1US_MAX + 1) : 1;
  localparam int unsigned MS_W    = (CNT_1MS_MAX > 0) ? $clog2(CNT_1MS_MAX + 1) : 1;
  localparam int unsigned POS_W   = $clog2(2 * N);
  localparam int unsigned SUM_MAX = POS_MAX + (CH_NUM - 1) * PHASE_STEP;
  // One spare count so the modulus 2N itself is representable.
  localparam int unsigned SUM_W   = $clog2(SUM_MAX + 2);
  localparam int unsigned CMP_W   = (MS_W > POS_W) ? MS_W : POS_W;

  typedef enum logic [1:0] {
    MODE_BREATH = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_STEADY = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [CH_NUM-1:0] LED_POL = '1;
`else
  localparam logic [CH_NUM-1:0] LED_POL = '0;
`endif

  logic [US_W-1:0]   cnt_1us;
  logic [MS_W-1:0]   cnt_1ms;
  logic [POS_W-1:0]  pos;
  mode_e             mode_q;
  logic              tick_us_c;
  logic              frame_end_c;
  logic              cycle_end_c;
  logic [CH_NUM-1:0] on_c;

  // Timebase strobes.
  always_comb begin
    tick_us_c   = (cnt_1us == US_W'(CNT_1US_MAX));
    frame_end_c = tick_us_c && (cnt_1ms == MS_W'(CNT_1MS_MAX));
    cycle_end_c = frame_end_c && (pos == POS_W'(POS_MAX));
  end

  // Counters, frame-aligned mode capture and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_1us    <= '0;
      cnt_1ms    <= '0;
      pos        <= '0;
      mode_q     <= MODE_OFF;
      cycle_done <= 1'b0;
      led_out    <= LED_POL;
    end else begin
      cnt_1us <= tick_us_c ? '0 : cnt_1us + US_W'(1);
      if (tick_us_c) begin
        cnt_1ms <= frame_end_c ? '0 : cnt_1ms + MS_W'(1);
      end
      if (frame_end_c) begin
        pos    <= cycle_end_c ? '0 : pos + POS_W'(1);
        mode_q <= mode_e'(mode);
      end
      cycle_done <= cycle_end_c;
      led_out    <= on_c ^ LED_POL;
    end
  end

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    localparam int unsigned OFFSET = gi * PHASE_STEP;

    logic [SUM_W-1:0] sum_c;
    logic [POS_W-1:0] pos_ch_c;
    logic [POS_W-1:0] bright_c;
    logic             on_ch_c;

    // Phase-shifted sweep position folded into a triangle brightness 0..N-1.
    always_comb begin
      sum_c    = SUM_W'(pos) + SUM_W'(OFFSET);
      pos_ch_c = POS_W'(sum_c % SUM_W'(2 * N));
      bright_c = (pos_ch_c < POS_W'(N)) ? pos_ch_c : POS_W'(POS_MAX) - pos_ch_c;
    end

    always_comb begin
      on_ch_c = 1'b0;
      case (mode_q)
        MODE_BREATH: on_ch_c = (CMP_W'(cnt_1ms) < CMP_W'(bright_c));
        MODE_BLINK:  on_ch_c = (pos_ch_c < POS_W'(N));
        MODE_STEADY: on_ch_c = 1'b1;
        MODE_OFF:    on_ch_c = 1'b0;
      endcase
    end

    assign on_c[gi] = on_ch_c & en[gi];
  end

endmodule

// File: tb/tb_breath_led_multi.sv
// Scoreboard bench for breath_led_multi: an arithmetic model of elapsed cycles predicts every output cycle.
module tb_breath_led_multi;

  localparam int CH    = 4;
  localparam int US    = 4;
  localparam int MS    = 9;
  localparam int S1    = 9;
  localparam int PS    = 5;
  localparam int N     = S1 + 1;
  localparam int FRAME = (US + 1) * (MS + 1);
  localparam int CYCLE = FRAME * 2 * N;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic [CH-1:0] en = '1;
  logic [CH-1:0] led_out;
  logic          cycle_done;

  breath_led_multi #(
    .CH_NUM(CH), .CNT_1US_MAX(US), .CNT_1MS_MAX(MS), .CNT_1S_MAX(S1), .PHASE_STEP(PS)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode(mode), .en(en),
    .led_out(led_out), .cycle_done(cycle_done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [CH-1:0] led;
    logic          cd;
    logic          in_rst;
    int            s;
  } exp_t;

  exp_t q[$];
  int   mode_hist[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   s_cnt = 0;
  int   cyc = 0;
  bit   started = 1'b0;
  bit   blink_win = 1'b0;
  int   blink_hi = 0;
  int   last_cd = -1;
  int   hi0[2*N] = '{default: 0};
  int   hi2[2*N] = '{default: 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected outputs after the edge that leaves state s (s clocks since reset release).
  function automatic exp_t ref_out(input int s, input logic [CH-1:0] e);
    exp_t r;
    int ms = (s / (US + 1)) % (MS + 1);
    int p  = (s / FRAME) % (2 * N);
    int mq = (s < FRAME) ? 3 : mode_hist[(s / FRAME) * FRAME - 1];
    r = '0;
    for (int i = 0; i < CH; i++) begin
      int  pi = (p + i * PS) % (2 * N);
      int  b  = (pi < N) ? pi : 2 * N - 1 - pi;
      logic on;
      case (mq)
        0:       on = (ms < b);
        1:       on = (pi < N);
        2:       on = 1'b1;
        default: on = 1'b0;
      endcase
      r.led[i] = on & e[i];
    end
    r.cd = ((s % CYCLE) == CYCLE - 1);
    r.s  = s;
    return r;
  endfunction

  // Model: one prediction pushed per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      cyc++;
      if (!sys_rst_n) begin
        s_cnt = 0;
        mode_hist.delete();
        e = '0;
        e.in_rst = 1'b1;
        e.s = -1;
      end else begin
        mode_hist.push_back(int'(mode));
        e = ref_out(s_cnt, en);
        s_cnt++;
      end
      q.push_back(e);
      started = 1'b1;
    end
  end

  // Monitor: pops one prediction per cycle and compares on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (started) begin
        if (q.size() == 0) begin
          chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
          e = q.pop_front();
          if (!sys_rst_n) begin
            e.led = '0;
            e.cd  = 1'b0;
            last_cd = -1;
          end
          chk("led_out", 32'(led_out), 32'(e.led));
          chk("cycle_done", 32'(cycle_done), 32'(e.cd));
          if (sys_rst_n && !e.in_rst) begin
            if (e.s >= CYCLE && e.s < 2 * CYCLE) begin
              hi0[(e.s / FRAME) % (2 * N)] += int'(led_out[0]);
              hi2[(e.s / FRAME) % (2 * N)] += int'(led_out[2]);
            end
            if (blink_win) blink_hi += int'(led_out[0]);
            if (cycle_done) begin
              if (last_cd >= 0) chk("cycle_done_period", 32'(cyc - last_cd), 32'(CYCLE));
              last_cd = cyc;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 sys_rst_n = 1'b0;
    mode = 2'b00;
    en = '1;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("reset_led", 32'(led_out), 32'd0);
    chk("reset_cycle_done", 32'(cycle_done), 32'd0);
    #1 sys_rst_n = 1'b1;

    // Two full breath cycles in breath mode with all channels enabled.
    repeat (2 * CYCLE + 100) @(posedge sys_clk);
    chk("breath_pos3_ch0", 32'(hi0[3]), 32'd15);
    chk("breath_pos3_ch2", 32'(hi2[3]), 32'd30);
    chk("breath_pos0_ch0", 32'(hi0[0]), 32'd0);
    chk("breath_pos0_ch2", 32'(hi2[0]), 32'd45);
    chk("breath_pos9_ch0", 32'(hi0[9]), 32'd45);

    // Steady, then drop one enable.
    #2 mode = 2'b10;
    repeat (60) @(posedge sys_clk);
    #2 en = 4'b1101;
    @(posedge sys_clk);
    #1 chk("en_drop", 32'(led_out), 32'b1101);

    // Randomized mode/enable traffic.
    for (int k = 0; k < 40; k++) begin
      @(posedge sys_clk);
      #2 mode = 2'($urandom_range(0, 3));
      en = CH'($urandom);
      repeat ($urandom_range(1, 80)) @(posedge sys_clk);
    end

    // Blink entered mid-frame: over any whole breath cycle ch0 is high exactly half.
    @(posedge sys_clk);
    #2 en = '1;
    mode = 2'b00;
    repeat (FRAME + 25) @(posedge sys_clk);
    #2 mode = 2'b01;
    repeat (100) @(posedge sys_clk);
    #2 blink_win = 1'b1;
    repeat (CYCLE) @(posedge sys_clk);
    #2 blink_win = 1'b0;
    chk("blink_high_count", 32'(blink_hi), 32'(CYCLE / 2));

    // Reset asserted mid-frame while all channels are on.
    mode = 2'b10;
    repeat (FRAME * 2 + 23) @(posedge sys_clk);
    #1 chk("pre_reset_led", 32'(led_out), 32'hF);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("async_reset_led", 32'(led_out), 32'd0);
    chk("async_reset_cd", 32'(cycle_done), 32'd0);
    repeat (2) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    repeat (300) @(posedge sys_clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/breath_led_multi.md
BREATH_LED_MULTI -- requirements
Module: breath_led_multi

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of independent LED channels (1..16).
REQ-002 SHALL have parameter CNT_1US_MAX, default 49, terminal count of the 1 us prescaler (50 MHz clock).
REQ-003 SHALL have parameter CNT_1MS_MAX, default 999, terminal count of the 1 ms (PWM frame) counter.
REQ-004 SHALL have parameter CNT_1S_MAX, default 999, terminal count of the 1 s (brightness step) counter; must equal CNT_1MS_MAX.
REQ-005 SHALL have parameter PHASE_STEP, default 250, brightness-position offset added per channel index.
REQ-006 SHALL have port sys_clk, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port mode, input, 2, global mode: 00 breath, 01 blink, 10 steady on, 11 off.
REQ-009 SHALL have port en, input, CH_NUM, per-channel enable.
REQ-010 SHALL have port led_out, output, CH_NUM, registered LED drive.
REQ-011 SHALL have port cycle_done, output, 1, one-cycle pulse at the end of each full breath cycle.

Function
REQ-012 cnt_1us SHALL count 0..CNT_1US_MAX and wrap; tick_us is asserted when cnt_1us == CNT_1US_MAX.
REQ-013 cnt_1ms SHALL advance on tick_us over 0..CNT_1MS_MAX and wrap; frame_end = tick_us && cnt_1ms == CNT_1MS_MAX.
REQ-014 pos SHALL advance on frame_end over 0..2N-1 (N = CNT_1S_MAX+1) and wrap to 0; pos < N is the rising half, pos >= N the falling half.
REQ-015 Per channel i, pos_i SHALL be (pos + i*PHASE_STEP) mod 2N, computed at a width sufficient to hold (2N-1) + (CH_NUM-1)*PHASE_STEP without overflow.
REQ-016 Brightness SHALL be b_i = pos_i if pos_i < N, otherwise 2N-1-pos_i, giving a range of 0..N-1.
REQ-017 Breath mode: the channel is on while cnt_1ms < b_i. Blink mode: on while pos_i < N. Steady: always on. Off: always off.
REQ-018 A channel with en[i]=0 SHALL be off regardless of mode.
REQ-019 led_out[i] SHALL be registered and reflect the counter, mode and enable state of the previous cycle (1-cycle latency).
REQ-020 mode SHALL be captured into mode_q only on frame_end; a mid-frame change of mode takes effect in the next frame, with no runt pulses.
REQ-021 en SHALL be sampled every cycle with no frame alignment.
REQ-022 cycle_done SHALL be high for exactly one cycle, the cycle after frame_end while pos == 2N-1, i.e. once per 2N frames.
REQ-023 b_i = 0 SHALL yield 0% duty; the maximum duty is (N-1)/N. No channel ever reaches 100% duty in breath mode.

Reset
REQ-024 While sys_rst_n is low, all counters, pos and cycle_done SHALL be 0, mode_q SHALL be 11, and led_out SHALL be at its inactive level, asynchronously.
REQ-025 After deassertion, counting SHALL start on the first rising edge; a reset asserted mid-cycle SHALL restart from pos 0 and cnt_1us 0.

Configuration
REQ-026 With macro LED_ACTIVE_LOW_EN defined, every led_out bit SHALL be inverted: "on" drives 0, and the reset/off level is 1.
REQ-027 Without LED_ACTIVE_LOW_EN, "on" drives 1, and the reset/off level is 0.

Verification
Common bench settings: CNT_1US_MAX=4, CNT_1MS_MAX=9, CNT_1S_MAX=9, CH_NUM=4, PHASE_STEP=5. This gives N=10, a 50-clock frame and a 1000-clock breath cycle.

REQ-028 Hold reset 2 cycles -> led_out=4'b0000 and cycle_done=0; after release with mode=00 and en=4'hF, mode_q becomes 00 after the first frame_end (cycle 50).
REQ-029 Breath, frame at pos=3 -> led_out[0] high for 15 of 50 clocks. In the same frame, led_out[2] (pos_i=13, b=6) is high for 30 clocks.
REQ-030 Frame at pos=0 -> led_out[0] low for all 50 clocks, while led_out[2] (pos_i=10, b=9) is high for 45 clocks.
REQ-031 Switch mode to 01 mid-frame -> behaviour unchanged until frame_end; afterwards led_out[0] is high for 500 consecutive clocks, then low for 500.
REQ-032 Free run -> cycle_done pulses exactly once every 1000 clocks. Dropping en[1] -> led_out[1]=0 one cycle later while other channels are unaffected. Asserting reset mid-frame -> all outputs 0 immediately.
